// File: rtl/note_synth.sv
// Square-wave note generator: accepts (key, octave, duration) commands and drives
// a 50%-duty tone on speaker, auto-stopping after the requested number of ms.
module note_synth #(
   parameter int CLK_HZ = 50_000_000,
   parameter int CNT_W  = 21,
   parameter int DUR_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             note_valid,
   output logic             note_ready,
   input  logic [3:0]       note_key,
   input  logic [2:0]       note_oct,
   input  logic [DUR_W-1:0] note_dur,
   input  logic             stop,
   output logic             speaker,
   output logic             playing,
   output logic             done
);

   localparam int MS    = CLK_HZ / 1000;
   localparam int PRE_W = (MS > 1) ? $clog2(MS) : 1;

   // Octave-0 pitches in mHz, C..B.
   localparam longint unsigned FREQ [12] = '{
      64'd16352, 64'd17324, 64'd18354, 64'd19445, 64'd20602, 64'd21827,
      64'd23125, 64'd24500, 64'd25957, 64'd27500, 64'd29135, 64'd30868
   };

   function automatic logic [CNT_W-1:0] base_of(input int k);
      longint unsigned v;
      v = (longint'(CLK_HZ) * 64'd1000) / (64'd2 * FREQ[k]);
      return v[CNT_W-1:0];
   endfunction

   // Rest keys 12..15 get a dummy entry so the 4-bit key indexes the full table.
   localparam logic [CNT_W-1:0] BASE [16] = '{
      base_of(0), base_of(1), base_of(2),  base_of(3),
      base_of(4), base_of(5), base_of(6),  base_of(7),
      base_of(8), base_of(9), base_of(10), base_of(11),
      CNT_W'(1),  CNT_W'(1),  CNT_W'(1),   CNT_W'(1)
   };

   typedef enum logic [1:0] {IDLE, PLAY, REST} state_t;

   state_t           state, state_nxt;
   logic             spk_nxt, done_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, half_r, half_nxt, half_sel, shifted;
   logic [PRE_W-1:0] pre, pre_nxt;
   logic [DUR_W-1:0] dur_cnt, dur_nxt;
   logic             wrap, timeout;

   assign shifted  = BASE[note_key] >> note_oct;
   assign half_sel = (shifted == '0) ? CNT_W'(1) : shifted;
   assign wrap     = (pre == PRE_W'(MS - 1));
   // dur_cnt==0 means "hold forever", so it never matches the final-ms test.
   assign timeout  = wrap && (dur_cnt == DUR_W'(1));

   assign note_ready = (state == IDLE);
   assign playing    = (state != IDLE);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      spk_nxt   = speaker;
      done_nxt  = 1'b0;
      cnt_nxt   = cnt;
      half_nxt  = half_r;
      pre_nxt   = pre;
      dur_nxt   = dur_cnt;
      unique case (state)
         IDLE: begin
            spk_nxt = 1'b0;
            if (note_valid) begin
               half_nxt = half_sel;
               dur_nxt  = note_dur;
               cnt_nxt  = '0;
               pre_nxt  = '0;
               if (note_key < 4'd12) begin
                  state_nxt = PLAY;
                  spk_nxt   = 1'b1;
               end else begin
                  state_nxt = REST;
               end
            end
         end
         default: begin
            pre_nxt = wrap ? '0 : pre + PRE_W'(1);
            if (wrap && dur_cnt != '0) dur_nxt = dur_cnt - DUR_W'(1);
            if (state == PLAY) begin
               if (cnt == half_r - CNT_W'(1)) begin
                  cnt_nxt = '0;
                  spk_nxt = ~speaker;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            // stop and timeout share one exit, so a coincidence still yields one done.
            if (stop || timeout) begin
               state_nxt = IDLE;
               spk_nxt   = 1'b0;
               done_nxt  = 1'b1;
               cnt_nxt   = '0;
               pre_nxt   = '0;
               dur_nxt   = '0;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         speaker <= 1'b0;
         done    <= 1'b0;
         cnt     <= '0;
         half_r  <= '0;
         pre     <= '0;
         dur_cnt <= '0;
      end else begin
         state   <= state_nxt;
         speaker <= spk_nxt;
         done    <= done_nxt;
         cnt     <= cnt_nxt;
         half_r  <= half_nxt;
         pre     <= pre_nxt;
         dur_cnt <= dur_nxt;
      end
   end

endmodule

// File: tb/tb_note_synth.sv
// Self-checking bench for note_synth: per-cycle comparison against an
// elapsed-time model of tone, duration, stop and handshake behaviour.
module tb_note_synth;

   localparam int CLK_HZ = 1_000_000;
   localparam int CNT_W  = 21;
   localparam int DUR_W  = 16;
   localparam int MS     = CLK_HZ / 1000;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             note_valid = 1'b0;
   logic             note_ready;
   logic [3:0]       note_key = '0;
   logic [2:0]       note_oct = '0;
   logic [DUR_W-1:0] note_dur = '0;
   logic             stop = 1'b0;
   logic             speaker, playing, done;

   int vectors = 0;
   int miscompares = 0;

   // Model: note in progress, elapsed cycles since the first tone cycle.
   bit      m_busy, m_play, m_done;
   longint  m_half, m_total, m_k;

   note_synth #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W), .DUR_W(DUR_W)) dut (
      .clk(clk), .rst_n(rst_n), .note_valid(note_valid), .note_ready(note_ready),
      .note_key(note_key), .note_oct(note_oct), .note_dur(note_dur),
      .stop(stop), .speaker(speaker), .playing(playing), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
      end
   endtask

   function automatic longint half_for(input int key, input int oct);
      longint f [12] = '{16352, 17324, 18354, 19445, 20602, 21827,
                         23125, 24500, 25957, 27500, 29135, 30868};
      longint h;
      h = ((longint'(CLK_HZ) * 1000) / (2 * f[key])) >> oct;
      return (h == 0) ? 1 : h;
   endfunction

   task automatic model_edge();
      m_done = 0;
      if (!m_busy) begin
         if (note_valid) begin
            m_busy  = 1;
            m_play  = (note_key < 12);
            m_half  = m_play ? half_for(note_key, note_oct) : 1;
            m_total = longint'(note_dur) * MS;
            m_k     = 0;
         end
      end else if (stop || (m_total != 0 && m_k + 1 == m_total)) begin
         m_busy = 0;
         m_done = 1;
      end else begin
         m_k++;
      end
   endtask

   task automatic compare();
      bit exp_spk;
      exp_spk = m_busy && m_play && (((m_k / m_half) % 2) == 0);
      check("speaker", speaker, exp_spk);
      check("playing", playing, m_busy);
      check("note_ready", note_ready, !m_busy);
      check("done", done, m_done);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   // Play one command; stop_k>=0 asserts stop in that elapsed cycle, poke
   // throws random competing commands at the busy block.
   task automatic run_note(input int key, input int oct, input int dur,
                           input longint stop_k, input bit poke);
      int n;
      note_valid = 1; note_key = 4'(key); note_oct = 3'(oct); note_dur = DUR_W'(dur);
      step();
      note_valid = 0;
      n = 0;
      while (m_busy && n < 20000) begin
         stop       = (stop_k >= 0 && m_k == stop_k);
         note_valid = poke && ($urandom_range(0, 7) == 0);
         note_key   = 4'($urandom_range(0, 15));
         note_oct   = 3'($urandom);
         note_dur   = DUR_W'($urandom_range(0, 3));
         step();
         n++;
      end
      stop = 0; note_valid = 0;
      if (m_busy) check("note_end_bound", 1, 0);
      step();
   endtask

   initial begin
      m_busy = 0; m_play = 0; m_done = 0; m_half = 1; m_total = 0; m_k = 0;
      #22 rst_n = 1;
      #1;
      compare();
      step();

      run_note(0, 5, 3, -1, 0);            // C5, timed
      run_note(12, 0, 2, -1, 0);           // rest, timed
      run_note(9, 4, 0, 10, 1);            // A4 held, pokes ignored, stop at 10
      stop = 1; step(); step(); stop = 0;  // stop in IDLE gives no done
      run_note(5, 3, 1, MS - 1, 0);        // stop coincides with timeout
      run_note(11, 7, 0, 700, 1);          // short half-period, held

      // Asynchronous reset in the middle of a note.
      note_valid = 1; note_key = 4'd2; note_oct = 3'd1; note_dur = '0;
      step();
      note_valid = 0;
      repeat (100) step();
      #2 rst_n = 0;
      #1;
      check("rst_speaker", speaker, 0);
      check("rst_playing", playing, 0);
      check("rst_ready", note_ready, 1);
      m_busy = 0; m_done = 0;
      @(negedge clk) rst_n = 1;
      step();

      for (int i = 0; i < 8; i++) begin
         int key, dur;
         key = $urandom_range(0, 15);
         dur = $urandom_range(0, 2);
         run_note(key, $urandom_range(0, 7), dur,
                  (dur == 0 || $urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 1500)) : -1,
                  1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
